// File: rtl/cvm300_sensor_emulator.sv
// CVM300 sensor emulator: streams one synthetic 10-bit frame per request
// with line-valid / data-valid framing, standing in for the sensor pins.
module cvm300_sensor_emulator #(
    parameter int unsigned H_PIXELS    = 648,
    parameter int unsigned V_LINES     = 488,
    parameter int unsigned LINE_GAP    = 16,
    parameter int unsigned FRAME_DELAY = 32
) (
    input  logic        FSM_Clk,
    input  logic        reset,
    input  logic        CVM300_FRAME_REQ,
    input  logic        CVM300_SYS_RES_N,
    input  logic [1:0]  pattern_sel,
    output logic [9:0]  CVM300_D,
    output logic        CVM300_Line_valid,
    output logic        CVM300_Data_valid,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    typedef enum logic [2:0] {IDLE, DELAY, LINE, GAP, DONE} state_t;

    localparam logic [31:0] COL_LAST = 32'(H_PIXELS - 1);
    localparam logic [31:0] ROW_LAST = 32'(V_LINES - 1);
    localparam logic [31:0] GAP_LAST = 32'(LINE_GAP - 1);
    localparam logic [31:0] DLY_LAST = 32'(FRAME_DELAY);

    state_t      state;
    logic        req_q;
    logic [1:0]  pat;
    logic [31:0] col;
    logic [31:0] row;
    logic [31:0] cnt;
    logic [31:0] pix;
    logic [15:0] fc_q;

    assign frame_count = fc_q;

    function automatic logic [9:0] pixel(
        input logic [1:0]  p,
        input logic [31:0] c,
        input logic [31:0] r,
        input logic [31:0] i,
        input logic [15:0] f
    );
        logic [9:0] v;
        v = '0;
        case (p)
            2'd0:    v = c[9:0];
            2'd1:    v = r[9:0];
            2'd2:    v = i[9:0] + f[9:0];
            default: v = {10{c[3] ^ r[3]}};
        endcase
        return v;
    endfunction

    // pix always holds the frame index of the pixel driven next (or now, in LINE)
    always_ff @(posedge FSM_Clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            req_q             <= 1'b0;
            pat               <= 2'd0;
            col               <= '0;
            row               <= '0;
            cnt               <= '0;
            pix               <= '0;
            fc_q              <= '0;
            busy              <= 1'b0;
            frame_done        <= 1'b0;
            CVM300_D          <= '0;
            CVM300_Line_valid <= 1'b0;
            CVM300_Data_valid <= 1'b0;
        end else begin
            req_q      <= CVM300_FRAME_REQ;
            frame_done <= 1'b0;
            if (!CVM300_SYS_RES_N) begin
                state             <= IDLE;
                busy              <= 1'b0;
                CVM300_D          <= '0;
                CVM300_Line_valid <= 1'b0;
                CVM300_Data_valid <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (CVM300_FRAME_REQ && !req_q) begin
                            pat   <= pattern_sel;
                            col   <= '0;
                            row   <= '0;
                            cnt   <= '0;
                            pix   <= '0;
                            busy  <= 1'b1;
                            state <= DELAY;
                        end
                    end
                    DELAY: begin
                        if (cnt == DLY_LAST) begin
                            state             <= LINE;
                            col               <= '0;
                            CVM300_Line_valid <= 1'b1;
                            CVM300_Data_valid <= 1'b1;
                            CVM300_D          <= pixel(pat, 32'd0, row, pix, fc_q);
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    LINE: begin
                        pix <= pix + 32'd1;
                        if (col == COL_LAST) begin
                            CVM300_Line_valid <= 1'b0;
                            CVM300_Data_valid <= 1'b0;
                            CVM300_D          <= '0;
                            if (row == ROW_LAST) begin
                                state      <= DONE;
                                frame_done <= 1'b1;
                                fc_q       <= fc_q + 16'd1;
                            end else begin
                                row   <= row + 32'd1;
                                cnt   <= '0;
                                state <= GAP;
                            end
                        end else begin
                            col      <= col + 32'd1;
                            CVM300_D <= pixel(pat, col + 32'd1, row,
                                              pix + 32'd1, fc_q);
                        end
                    end
                    GAP: begin
                        if (cnt == GAP_LAST) begin
                            state             <= LINE;
                            col               <= '0;
                            CVM300_Line_valid <= 1'b1;
                            CVM300_Data_valid <= 1'b1;
                            CVM300_D          <= pixel(pat, 32'd0, row, pix, fc_q);
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cvm300_sensor_emulator.sv
// Randomized bench for cvm300_sensor_emulator: each frame is compared cycle
// by cycle against an expected waveform built from the frame geometry.
module tb_cvm300_sensor_emulator;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int G  = 2;
    localparam int FD = 3;

    typedef struct {
        bit          lv;
        logic [9:0]  d;
        bit          busy;
        bit          done;
        logic [15:0] fc;
    } exp_t;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        req  = 1'b0;
    logic        sres = 1'b1;
    logic [1:0]  psel = 2'd0;
    logic [9:0]  d;
    logic        lv;
    logic        dv;
    logic        busy;
    logic        done;
    logic [15:0] fc;

    int          n_chk = 0;
    int          n_pass = 0;
    int          n_frame = 0;
    logic [15:0] m_fc = 16'd0;

    always #5 clk = ~clk;

    cvm300_sensor_emulator #(
        .H_PIXELS(H), .V_LINES(V), .LINE_GAP(G), .FRAME_DELAY(FD)
    ) dut (
        .FSM_Clk(clk),
        .reset(rst),
        .CVM300_FRAME_REQ(req),
        .CVM300_SYS_RES_N(sres),
        .pattern_sel(psel),
        .CVM300_D(d),
        .CVM300_Line_valid(lv),
        .CVM300_Data_valid(dv),
        .busy(busy),
        .frame_done(done),
        .frame_count(fc)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_cyc(input string tag, input exp_t e);
        chk({tag, ".lv"},   32'(lv),   32'(e.lv));
        chk({tag, ".dv"},   32'(dv),   32'(e.lv));
        chk({tag, ".d"},    32'(d),    32'(e.d));
        chk({tag, ".busy"}, 32'(busy), 32'(e.busy));
        chk({tag, ".done"}, 32'(done), 32'(e.done));
        chk({tag, ".fc"},   32'(fc),   32'(e.fc));
    endtask

    function automatic exp_t quiet(input bit b);
        exp_t e;
        e = '{0, 10'd0, b, 0, m_fc};
        return e;
    endfunction

    function automatic logic [9:0] ref_pix(input logic [1:0] p, input int c,
                                           input int r, input int i);
        int v;
        case (p)
            2'd0:    v = c % 1024;
            2'd1:    v = r % 1024;
            2'd2:    v = (i + int'(m_fc)) % 1024;
            default: v = (((c / 8) ^ (r / 8)) % 2 == 1) ? 1023 : 0;
        endcase
        return 10'(v);
    endfunction

    // cut >= 0: drop SYS_RES_N after checking trace cycle cut
    task automatic run_frame(input logic [1:0] p, input bit hold,
                             input bit pulse, input int cut);
        exp_t q[$];
        exp_t e;
        int   idx;
        bit   aborted;
        idx = 0;
        aborted = 0;
        n_frame++;
        repeat (FD + 1) q.push_back(quiet(1));
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                e = '{1, ref_pix(p, c, r, idx), 1, 0, m_fc};
                q.push_back(e);
                idx++;
            end
            if (r < V - 1) repeat (G) q.push_back(quiet(1));
        end
        e = '{0, 10'd0, 1, 1, m_fc + 16'd1};
        q.push_back(e);

        @(negedge clk);
        req  = 1'b1;
        psel = p;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            chk_cyc($sformatf("f%0d.c%0d", n_frame, i), q[i]);
            psel = 2'($urandom);
            if (!hold && i == 0) req = 1'b0;
            if (pulse && i == 15) req = 1'b0;
            if (pulse && i == 16) req = 1'b1;
            if (i == cut) begin
                sres = 1'b0;
                aborted = 1;
                break;
            end
        end

        if (aborted) begin
            @(negedge clk);
            chk_cyc($sformatf("f%0d.sres", n_frame), quiet(0));
            req = 1'b0;
            @(negedge clk);
            req = 1'b1;
            repeat (4) begin
                @(negedge clk);
                chk_cyc($sformatf("f%0d.sres_req", n_frame), quiet(0));
            end
            sres = 1'b1;
            repeat (3) begin
                @(negedge clk);
                chk_cyc($sformatf("f%0d.sres_rel", n_frame), quiet(0));
            end
        end else begin
            m_fc = m_fc + 16'd1;
            repeat (3) begin
                @(negedge clk);
                chk_cyc($sformatf("f%0d.idle", n_frame), quiet(0));
            end
        end
        req = 1'b0;
    endtask

    initial begin
        #1;
        chk_cyc("reset", quiet(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // asynchronous reset in the middle of the first line
        req = 1'b1;
        repeat (8) @(negedge clk);
        chk("pre_rst.lv", 32'(lv), 32'd1);
        #2;
        rst = 1'b1;
        req = 1'b0;
        #1;
        chk_cyc("async_rst", quiet(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk_cyc("post_rst", quiet(0));
        end

        run_frame(2'd0, 0, 0, -1);
        run_frame(2'd2, 0, 0, -1);
        run_frame(2'd1, 0, 0, -1);
        run_frame(2'd3, 0, 0, -1);
        run_frame(2'($urandom), 1, 1, -1);
        run_frame(2'($urandom), 0, 0, -1);
        run_frame(2'($urandom), 0, 0, FD + 1 + 2 * (H + G) + 3);
        run_frame(2'($urandom), 0, 0, -1);

        @(negedge clk);
        force dut.fc_q = 16'hFFFF;
        @(negedge clk);
        release dut.fc_q;
        m_fc = 16'hFFFF;
        @(negedge clk);
        chk("preload.fc", 32'(fc), 32'(m_fc));
        run_frame(2'd2, 0, 0, -1);
        run_frame(2'($urandom), 0, 0, -1);

        for (int k = 0; k < 6; k++) begin
            run_frame(2'($urandom), 1'($urandom), 1'($urandom), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
